// File: rtl/bound_flasher_pkg.sv
// Shared types, default sweep bounds and a packed-list slice helper for the
// bound flasher family.
package bound_flasher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NPHASE = 3;

  // Phase 0 lives in the least significant slice: tops 16/11/6, bottoms 5/0/0.
  localparam logic [14:0] DEF_TOP_LIST = {5'd6, 5'd11, 5'd16};
  localparam logic [14:0] DEF_BOT_LIST = {5'd0, 5'd0, 5'd5};
  localparam int          DEF_KB0      = 0;
  localparam int          DEF_KB1      = 5;

  function automatic int list_slice(input logic [63:0] list, input int cw, input int k);
    logic [63:0] mask;
    mask = (64'd1 << cw) - 64'd1;
    return int'((list >> (k * cw)) & mask);
  endfunction

endpackage

// File: rtl/bound_flasher_multi_if.sv
// Request/status bundle between the board LED driver and the flasher.
interface bound_flasher_multi_if #(
  parameter int WIDTH  = 16,
  parameter int NPHASE = 3
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;

  logic             FLICK;
  logic             LOOP;
  logic [WIDTH-1:0] LED;
  logic [CW-1:0]    LEVEL;
  logic [PW-1:0]    PHASE;
  logic             BUSY;
  logic             DONE;

  modport master (
    output FLICK, LOOP,
    input  LED, LEVEL, PHASE, BUSY, DONE
  );

  modport slave (
    input  FLICK, LOOP,
    output LED, LEVEL, PHASE, BUSY, DONE
  );
endinterface

// File: rtl/bound_flasher_multi_thermo_decode.sv
// Lit-count to thermometer code: bit i is lit whenever cnt exceeds i.
module thermo_decode #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] therm
);
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign therm[gi] = (cnt > CW'(gi));
  end
endmodule

// File: rtl/bound_flasher_multi.sv
// Multi-phase bounded LED sweep sequencer with flick-triggered kickback,
// optional looping and run status.
module bound_flasher_multi
  import bound_flasher_pkg::*;
#(
  parameter int                   WIDTH    = DEF_WIDTH,
  parameter int                   NPHASE   = DEF_NPHASE,
  parameter int                   CW       = $clog2(WIDTH + 1),
  parameter logic [NPHASE*CW-1:0] TOP_LIST = DEF_TOP_LIST,
  parameter logic [NPHASE*CW-1:0] BOT_LIST = DEF_BOT_LIST,
  parameter int                   KB0      = DEF_KB0,
  parameter int                   KB1      = DEF_KB1
) (
  input logic                  CLK,
  input logic                  RST,
  bound_flasher_multi_if.slave bus
);
  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_UP   = UP;
  localparam logic [1:0] S_DOWN = DOWN;

  localparam logic [CW-1:0] KB0_C  = CW'(KB0);
  localparam logic [CW-1:0] KB1_C  = CW'(KB1);
  localparam logic [PW-1:0] LAST_P = PW'(NPHASE - 1);

  logic [CW-1:0] top_arr [2**PW];
  logic [CW-1:0] bot_arr [2**PW];

  if (WIDTH < 4 || WIDTH > 64 || NPHASE < 1 || NPHASE > 8 ||
      CW != $clog2(WIDTH + 1) || KB0 > WIDTH || KB1 > WIDTH) begin : g_bad_params
    $fatal(1, "bound_flasher_multi: parameter out of range");
  end

  // Unreachable phase slots are padded so the phase index never reads past the table.
  genvar gi;
  for (gi = 0; gi < 2**PW; gi++) begin : g_bounds
    if (gi < NPHASE) begin : g_used
      localparam int TK = list_slice(64'(TOP_LIST), CW, gi);
      localparam int BK = list_slice(64'(BOT_LIST), CW, gi);
      assign top_arr[gi] = CW'(TK);
      assign bot_arr[gi] = CW'(BK);
      if (!(BK < TK && TK <= WIDTH)) begin : g_bad_order
        $fatal(1, "bound_flasher_multi: phase bottom/top out of order");
      end
      if (gi + 1 < NPHASE) begin : g_next
        localparam int TN = list_slice(64'(TOP_LIST), CW, gi + 1);
        if (BK >= TN) begin : g_bad_next
          $fatal(1, "bound_flasher_multi: bottom not below next phase top");
        end
      end
      // LOOP is a live input, so the wrap back to phase 0 must always start from 0.
      if (gi == NPHASE - 1 && BK != 0) begin : g_bad_last
        $fatal(1, "bound_flasher_multi: final phase bottom must be 0");
      end
    end else begin : g_pad
      assign top_arr[gi] = '0;
      assign bot_arr[gi] = '0;
    end
  end

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] ph_reg, ph_next;
  logic          flick_q_reg;
  logic          done_reg, done_next;

  logic          flick_rise;
  logic          last_ph;
  logic          kb_win;
  logic [CW-1:0] top_cur;
  logic [CW-1:0] bot_cur;

  assign flick_rise = bus.FLICK & ~flick_q_reg;
  assign last_ph    = (ph_reg == LAST_P);
  assign top_cur    = top_arr[ph_reg];
  assign bot_cur    = bot_arr[ph_reg];
  assign kb_win     = (state_reg == S_DOWN) && !last_ph &&
                      ((cnt_reg == KB0_C) || (cnt_reg == KB1_C));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ph_next    = ph_reg;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (flick_rise) begin
          state_next = S_UP;
          cnt_next   = '0;
          ph_next    = '0;
        end
      end
      S_UP: begin
        if (cnt_reg == top_cur) begin
          state_next = S_DOWN;
          cnt_next   = cnt_reg - CW'(1);
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DOWN: begin
        // Kickback outranks the bottom turn-around, even when both match.
        if (flick_rise && kb_win) begin
          state_next = S_UP;
        end else if (cnt_reg == bot_cur) begin
          if (!last_ph) begin
            state_next = S_UP;
            ph_next    = ph_reg + PW'(1);
            cnt_next   = cnt_reg + CW'(1);
          end else if (bus.LOOP) begin
            state_next = S_UP;
            ph_next    = '0;
            cnt_next   = cnt_reg + CW'(1);
          end else begin
            state_next = S_IDLE;
            ph_next    = '0;
            cnt_next   = '0;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        ph_next    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      ph_reg      <= '0;
      flick_q_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ph_reg      <= ph_next;
      flick_q_reg <= bus.FLICK;
      done_reg    <= done_next;
    end
  end

  thermo_decode #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_thermo (
    .cnt   (cnt_reg),
    .therm (bus.LED)
  );

  assign bus.LEVEL = cnt_reg;
  assign bus.PHASE = ph_reg;
  assign bus.BUSY  = (state_reg != S_IDLE);
  assign bus.DONE  = done_reg;

endmodule
